// File: rtl/ped_request_pkg.sv
// Shared definitions for the pedestrian request input stage: debounce state
// encoding, wait-counter limits and board-level defaults.
package ped_request_pkg;

    typedef logic [1:0] db_state_t;

    localparam db_state_t DB_UP       = 2'd0;
    localparam db_state_t DB_UP_CHK   = 2'd1;
    localparam db_state_t DB_DOWN     = 2'd2;
    localparam db_state_t DB_DOWN_CHK = 2'd3;

    localparam int unsigned WAIT_W   = 6;
    localparam int unsigned WAIT_MAX = 63;

    localparam int unsigned CLK_HZ_DEFAULT       = 50_000_000;
    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 1_000_000;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ped_request_debounce.sv
// Two-flop synchronizer plus four-state debounce FSM for one active-low key.
// Emits the debounced level and a one-cycle press pulse on entry to DOWN.
module ped_request_debounce
    import ped_request_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      key_n,
    output logic      level,
    output logic      press,
    output db_state_t state
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W:0] CNT_LAST = (CNT_W + 1)'(DEBOUNCE_CYC - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    db_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;
    logic [CNT_W:0]  cnt_next;
    logic            cnt_done;

    always_comb begin
        s1_d     = key_n;
        s2_d     = s1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        cnt_next = {1'b0, cnt_q} + 1'b1;
        // The sample that opened the CHK state already counts as the first one.
        cnt_done = (cnt_next >= CNT_LAST);

        case (state_q)
            DB_UP: begin
                if (!s2_q) begin
                    state_d = DB_UP_CHK;
                    cnt_d   = '0;
                end
            end
            DB_UP_CHK: begin
                if (s2_q) begin
                    state_d = DB_UP;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = DB_DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_next[CNT_W-1:0];
                end
            end
            DB_DOWN: begin
                if (s2_q) begin
                    state_d = DB_DOWN_CHK;
                    cnt_d   = '0;
                end
            end
            DB_DOWN_CHK: begin
                if (!s2_q) begin
                    state_d = DB_DOWN;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = DB_UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_next[CNT_W-1:0];
                end
            end
            default: begin
                state_d = DB_UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            state_q <= DB_UP;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign level = (state_q == DB_DOWN) || (state_q == DB_DOWN_CHK);
    assign press = press_q;
    assign state = state_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian input stage: free-running tick timebase, debounced key,
// latched walk request with ack handshake, and saturating wait-seconds counter.
module ped_request
    import ped_request_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ      = 1,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              key_n,
    input  logic              ped_ack,
    output logic              tick,
    output logic              ped_pressed,
    output logic              ped_req,
    output logic [WAIT_W-1:0] wait_s
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned TB_W = cnt_width(DIV);
    localparam logic [TB_W-1:0]   TB_LAST  = TB_W'(DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(WAIT_MAX);

    logic [TB_W-1:0]   tb_cnt_q, tb_cnt_d;
    logic              tick_q, tick_d;
    logic              ped_req_q, ped_req_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              db_level;
    logic              db_press;
    db_state_t         db_state;
    logic              fresh_req;

    ped_request_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (CLOCK_50),
        .rst   (rst),
        .key_n (key_n),
        .level (db_level),
        .press (db_press),
        .state (db_state)
    );

    always_comb begin
        tb_cnt_d = (tb_cnt_q == TB_LAST) ? '0 : tb_cnt_q + 1'b1;
        tick_d   = (tb_cnt_d == TB_LAST);

        // A press coinciding with an ack re-arms the request rather than dropping it.
        fresh_req = db_press && (!ped_req_q || ped_ack);
        ped_req_d = db_press || (ped_req_q && !ped_ack);

        wait_d = wait_q;
        if (!ped_req_d || fresh_req) begin
            wait_d = '0;
        end else if (tick_q && (wait_q != WAIT_SAT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            tb_cnt_q  <= '0;
            tick_q    <= 1'b0;
            ped_req_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            tb_cnt_q  <= tb_cnt_d;
            tick_q    <= tick_d;
            ped_req_q <= ped_req_d;
            wait_q    <= wait_d;
        end
    end

    assign tick        = tick_q;
    assign ped_pressed = db_level;
    assign ped_req     = ped_req_q;
    assign wait_s      = wait_q;

    a_press_in_down: assert property (@(posedge CLOCK_50) disable iff (rst)
        db_press |-> (db_state == DB_DOWN));

endmodule
